// File: rtl/riscv_types.sv
// Shared types for the execution issue scheduler: unit indices,
// widths and the writeback tag carried through the per-unit tag FIFOs.
package riscv_types;

    localparam int NUM_UNITS = 9;
    localparam int RD_W      = 5;

    localparam int UNIT_ALU     = 8;
    localparam int UNIT_FPU     = 7;
    localparam int UNIT_MUL     = 6;
    localparam int UNIT_FADDSUB = 5;
    localparam int UNIT_FMUL    = 4;
    localparam int UNIT_R4      = 3;
    localparam int UNIT_FDIV    = 2;
    localparam int UNIT_DIV     = 1;
    localparam int UNIT_FSQRT   = 0;

    typedef struct packed {
        logic            fp;
        logic [RD_W-1:0] rd;
    } wb_tag_t;

    function automatic logic is_onehot(
        input logic [NUM_UNITS-1:0] v
    );
        return $onehot(v);
    endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// In-order destination-tag FIFO for one execution unit, with a
// content match used by the issue stage for WAW hazard detection.
module sched_tag_fifo
    import riscv_types::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  logic    i_pop,
    input  wb_tag_t i_din,
    input  wb_tag_t i_cmp,
    output logic    o_full,
    output logic    o_empty,
    output wb_tag_t o_head,
    output logic    o_hit,
    output logic    o_hit_head_only
);

    localparam int CW = $clog2(DEPTH + 1);

    wb_tag_t          r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_widx;
    logic [DEPTH-1:0] w_match;
    logic             w_match_tail;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[0];

    // Entries shift toward index 0 on pop, so a same-cycle push
    // lands one slot lower than it would otherwise.
    assign w_widx = i_pop ? (r_count - CW'(1)) : r_count;

    always_comb begin
        w_match      = '0;
        w_match_tail = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = (CW'(i) < r_count) && (r_mem[i] == i_cmp);
            if (i > 0) begin
                w_match_tail = w_match_tail | w_match[i];
            end
        end
    end

    assign o_hit           = |w_match;
    assign o_hit_head_only = w_match[0] & ~w_match_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            if (i_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (i_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_widx) begin
                        r_mem[i] <= i_din;
                    end
                end
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

endmodule

// File: rtl/exec_issue_scheduler.sv
// Issue gating, per-unit tag tracking and writeback arbitration.
// Define SCHED_AGING_EN to promote starved units after AGE_LIMIT waits.
module exec_issue_scheduler
    import riscv_types::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int AGE_LIMIT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [NUM_UNITS-1:0] issue_unit,
    input  logic [RD_W-1:0]      issue_rd,
    input  logic                 issue_fp,
    output logic                 issue_ready,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_hold,
    output logic [NUM_UNITS-1:0] wb_grant,
    output logic                 wb_valid,
    output logic [RD_W-1:0]      wb_rd,
    output logic                 wb_fp,
    output logic [NUM_UNITS-1:0] busy_vec,
    output logic                 protocol_err
);

    wb_tag_t                w_issue_tag;
    wb_tag_t                w_head [NUM_UNITS];
    wb_tag_t                w_wb;
    logic [NUM_UNITS-1:0]   w_full;
    logic [NUM_UNITS-1:0]   w_empty;
    logic [NUM_UNITS-1:0]   w_hit;
    logic [NUM_UNITS-1:0]   w_hit_head;
    logic [NUM_UNITS-1:0]   w_elig;
    logic [NUM_UNITS-1:0]   w_pool;
    logic [NUM_UNITS-1:0]   w_grant;
    logic                   w_onehot;
    logic                   w_nounit;
    logic                   w_waw_exempt;
    logic                   w_hazard;
    logic                   w_full_blk;
    logic                   w_accept;
    logic                   r_perr;

    assign w_issue_tag = '{fp: issue_fp, rd: issue_rd};

    genvar u;
    generate
        for (u = 0; u < NUM_UNITS; u++) begin : g_fifo
            localparam int D =
                (u >= UNIT_R4 && u <= UNIT_FADDSUB) ? PIPE_DEPTH : 1;
            sched_tag_fifo #(.DEPTH(D)) u_fifo (
                .clk             (clk),
                .rst             (rst),
                .i_push          (unit_start[u]),
                .i_pop           (w_grant[u]),
                .i_din           (w_issue_tag),
                .i_cmp           (w_issue_tag),
                .o_full          (w_full[u]),
                .o_empty         (w_empty[u]),
                .o_head          (w_head[u]),
                .o_hit           (w_hit[u]),
                .o_hit_head_only (w_hit_head[u])
            );
        end
    endgenerate

    assign busy_vec = ~w_empty;
    assign w_elig   = unit_done & busy_vec & {NUM_UNITS{~rst}};

`ifdef SCHED_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0]        r_age [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_aged;

    always_comb begin
        w_aged = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_aged[i] = (r_age[i] >= AW'(AGE_LIMIT));
        end
        w_pool = (|(w_elig & w_aged)) ? (w_elig & w_aged) : w_elig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_grant[i]) begin
                    r_age[i] <= '0;
                end else if (w_elig[i] && r_age[i] != AW'(AGE_LIMIT)) begin
                    r_age[i] <= r_age[i] + AW'(1);
                end
            end
        end
    end
`else
    assign w_pool = w_elig;
`endif

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_pool[i]) begin
                w_grant = NUM_UNITS'(1) << i;
            end
        end
    end

    always_comb begin
        w_wb = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_grant[i]) begin
                w_wb = w_head[i];
            end
        end
    end

    assign wb_grant  = w_grant;
    assign wb_valid  = |w_grant;
    assign wb_rd     = w_wb.rd;
    assign wb_fp     = w_wb.fp;
    assign unit_hold = unit_done & ~w_grant & {NUM_UNITS{~rst}};

    assign w_onehot     = is_onehot(issue_unit);
    assign w_nounit     = (issue_unit == '0);
    assign w_waw_exempt = ~issue_fp && (issue_rd == '0);
    // A match held only at the head of a FIFO draining this cycle
    // is gone by the time the new tag lands.
    assign w_hazard     = ~w_waw_exempt &
                          (|(w_hit & ~(w_hit_head & w_grant)));
    assign w_full_blk   = |(issue_unit & w_full & ~w_grant);
    assign w_accept     = issue_valid & ~rst & w_onehot &
                          ~w_full_blk & ~w_hazard;

    assign issue_ready = issue_valid & (rst | w_nounit | w_accept);
    assign unit_start  = w_accept ? issue_unit : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if ((issue_valid & ~w_nounit & ~w_onehot) |
                     (|(unit_done & w_empty))) begin
            r_perr <= 1'b1;
        end
    end

    assign protocol_err = r_perr;

endmodule

// File: tb/tb_exec_issue_scheduler.sv
// Directed table-driven bench for exec_issue_scheduler plus
// hand-written multi-cycle sequences (FIFO depth, starvation, errors).
module tb_exec_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [8:0] issue_unit;
    logic [4:0] issue_rd;
    logic       issue_fp;
    logic       issue_ready;
    logic [8:0] unit_start;
    logic [8:0] unit_done;
    logic [8:0] unit_hold;
    logic [8:0] wb_grant;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_fp;
    logic [8:0] busy_vec;
    logic       protocol_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    exec_issue_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_rd     (issue_rd),
        .issue_fp     (issue_fp),
        .issue_ready  (issue_ready),
        .unit_start   (unit_start),
        .unit_done    (unit_done),
        .unit_hold    (unit_hold),
        .wb_grant     (wb_grant),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_fp        (wb_fp),
        .busy_vec     (busy_vec),
        .protocol_err (protocol_err)
    );

    typedef struct {
        logic       v;
        logic [8:0] unit;
        logic [4:0] rd;
        logic       fp;
        logic [8:0] done;
        logic       e_ready;
        logic [8:0] e_start;
        logic [8:0] e_grant;
        logic [4:0] e_rd;
        logic       e_fp;
        logic [8:0] e_hold;
        logic [8:0] e_busy;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(
        input logic v, input logic [8:0] unit,
        input logic [4:0] rd, input logic fp,
        input logic [8:0] done, input logic e_ready,
        input logic [8:0] e_start, input logic [8:0] e_grant,
        input logic [4:0] e_rd, input logic e_fp,
        input logic [8:0] e_hold, input logic [8:0] e_busy
    );
        vec_t r;
        r.v = v; r.unit = unit; r.rd = rd; r.fp = fp;
        r.done = done; r.e_ready = e_ready;
        r.e_start = e_start; r.e_grant = e_grant;
        r.e_rd = e_rd; r.e_fp = e_fp;
        r.e_hold = e_hold; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(
        input logic v, input logic [8:0] unit,
        input logic [4:0] rd, input logic fp,
        input logic [8:0] done
    );
        @(negedge clk);
        issue_valid = v;
        issue_unit  = unit;
        issue_rd    = rd;
        issue_fp    = fp;
        unit_done   = done;
        #1;
    endtask

    int got;

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_unit  = '0;
        issue_rd    = '0;
        issue_fp    = 1'b0;
        unit_done   = '0;
        repeat (2) @(posedge clk);

        set_in(1, 9'h100, 5, 0, 9'h000);
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_start", 32'(unit_start), 0);
        chk("rst_busy", 32'(busy_vec), 0);
        chk("rst_grant", 32'(wb_grant), 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_perr", 32'(protocol_err), 0);
        set_in(0, 9'h000, 0, 0, 9'h000);
        rst = 1'b0;

        tbl[0]  = mk(0,9'h000,0,0,9'h000, 0,9'h000,9'h000,0,0,9'h000,9'h000);
        tbl[1]  = mk(1,9'h100,5,0,9'h000, 1,9'h100,9'h000,0,0,9'h000,9'h000);
        tbl[2]  = mk(0,9'h000,0,0,9'h100, 0,9'h000,9'h100,5,0,9'h000,9'h100);
        tbl[3]  = mk(0,9'h000,0,0,9'h000, 0,9'h000,9'h000,0,0,9'h000,9'h000);
        tbl[4]  = mk(1,9'h002,3,0,9'h000, 1,9'h002,9'h000,0,0,9'h000,9'h000);
        tbl[5]  = mk(1,9'h004,4,0,9'h000, 1,9'h004,9'h000,0,0,9'h000,9'h002);
        tbl[6]  = mk(1,9'h002,7,0,9'h006, 0,9'h000,9'h004,4,0,9'h002,9'h006);
        tbl[7]  = mk(1,9'h002,7,0,9'h002, 1,9'h002,9'h002,3,0,9'h000,9'h002);
        tbl[8]  = mk(0,9'h000,0,0,9'h002, 0,9'h000,9'h002,7,0,9'h000,9'h002);
        tbl[9]  = mk(0,9'h000,0,0,9'h000, 0,9'h000,9'h000,0,0,9'h000,9'h000);
        tbl[10] = mk(1,9'h004,9,1,9'h000, 1,9'h004,9'h000,0,0,9'h000,9'h000);
        tbl[11] = mk(1,9'h100,9,0,9'h000, 1,9'h100,9'h000,0,0,9'h000,9'h004);
        tbl[12] = mk(1,9'h020,9,1,9'h000, 0,9'h000,9'h000,0,0,9'h000,9'h104);
        tbl[13] = mk(1,9'h020,9,1,9'h100, 0,9'h000,9'h100,9,0,9'h000,9'h104);
        tbl[14] = mk(1,9'h020,9,1,9'h004, 1,9'h020,9'h004,9,1,9'h000,9'h004);
        tbl[15] = mk(1,9'h100,0,0,9'h000, 1,9'h100,9'h000,0,0,9'h000,9'h020);
        tbl[16] = mk(1,9'h040,0,0,9'h000, 1,9'h040,9'h000,0,0,9'h000,9'h120);
        tbl[17] = mk(1,9'h000,0,0,9'h160, 1,9'h000,9'h100,0,0,9'h060,9'h160);
        tbl[18] = mk(0,9'h000,0,0,9'h060, 0,9'h000,9'h040,0,0,9'h020,9'h060);
        tbl[19] = mk(0,9'h000,0,0,9'h020, 0,9'h000,9'h020,9,1,9'h000,9'h020);
        tbl[20] = mk(0,9'h000,0,0,9'h000, 0,9'h000,9'h000,0,0,9'h000,9'h000);

        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].v, tbl[i].unit, tbl[i].rd,
                   tbl[i].fp, tbl[i].done);
            chk($sformatf("v%0d_ready", i),
                32'(issue_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_start", i),
                32'(unit_start), 32'(tbl[i].e_start));
            chk($sformatf("v%0d_grant", i),
                32'(wb_grant), 32'(tbl[i].e_grant));
            chk($sformatf("v%0d_wbv", i),
                32'(wb_valid), 32'(tbl[i].e_grant != 0));
            chk($sformatf("v%0d_wbrd", i),
                32'(wb_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_wbfp", i),
                32'(wb_fp), 32'(tbl[i].e_fp));
            chk($sformatf("v%0d_hold", i),
                32'(unit_hold), 32'(tbl[i].e_hold));
            chk($sformatf("v%0d_busy", i),
                32'(busy_vec), 32'(tbl[i].e_busy));
        end
        chk("tbl_perr", 32'(protocol_err), 0);

        // FMUL depth-4 FIFO: fifth issue waits for a writeback
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 9'h010, 5'(k), 0, 9'h000);
            chk($sformatf("fmul_issue%0d", k), 32'(issue_ready), 1);
        end
        set_in(1, 9'h010, 5, 0, 9'h000);
        chk("fmul_fifth_stall", 32'(issue_ready), 0);
        set_in(1, 9'h010, 5, 0, 9'h010);
        chk("fmul_fifth_ready", 32'(issue_ready), 1);
        chk("fmul_fifth_start", 32'(unit_start), 32'h010);
        chk("fmul_wb1", 32'(wb_rd), 1);
        for (int k = 2; k <= 5; k++) begin
            set_in(0, 9'h000, 0, 0, 9'h010);
            chk($sformatf("fmul_wb%0d", k), 32'(wb_rd), k);
            chk($sformatf("fmul_gnt%0d", k), 32'(wb_grant), 32'h010);
        end
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("fmul_drained", 32'(busy_vec), 0);

        // FSQRT done held while ALU completes every cycle
        set_in(1, 9'h001, 10, 0, 9'h000);
        chk("fsqrt_issue", 32'(issue_ready), 1);
        set_in(1, 9'h100, 12, 0, 9'h000);
        chk("alu_prime", 32'(issue_ready), 1);
        got = -1;
        for (int j = 0; j < 12; j++) begin
            set_in(1, 9'h100, 12, 0, (got < 0) ? 9'h101 : 9'h100);
            if (got < 0 && wb_grant == 9'h001) got = j;
        end
`ifdef SCHED_AGING_EN
        chk("fsqrt_grant_cycle", 32'(got), 8);
`else
        chk("fsqrt_grant_cycle", 32'(got), 32'hffff_ffff);
        set_in(0, 9'h000, 0, 0, 9'h001);
        chk("fsqrt_late_gnt", 32'(wb_grant), 32'h001);
        chk("fsqrt_late_rd", 32'(wb_rd), 10);
`endif
        set_in(0, 9'h000, 0, 0, 9'h100);
        chk("alu_drain", 32'(wb_grant), 32'h100);
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("age_busy", 32'(busy_vec), 0);
        chk("age_perr", 32'(protocol_err), 0);

        // done with empty FIFO
        set_in(0, 9'h000, 0, 0, 9'h010);
        chk("empty_done_gnt", 32'(wb_grant), 0);
        chk("empty_done_hold", 32'(unit_hold), 32'h010);
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("empty_done_perr", 32'(protocol_err), 1);
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("perr_sticky", 32'(protocol_err), 1);
        rst = 1'b1;
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("perr_rst", 32'(protocol_err), 0);
        rst = 1'b0;

        // non-one-hot select
        set_in(1, 9'h003, 1, 0, 9'h000);
        chk("multi_ready", 32'(issue_ready), 0);
        chk("multi_start", 32'(unit_start), 0);
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("multi_perr", 32'(protocol_err), 1);

        // reset mid-operation discards in-flight tags
        rst = 1'b1;
        set_in(0, 9'h000, 0, 0, 9'h000);
        rst = 1'b0;
        set_in(1, 9'h100, 6, 0, 9'h000);
        chk("mid_issue", 32'(issue_ready), 1);
        set_in(0, 9'h000, 0, 0, 9'h000);
        chk("mid_busy", 32'(busy_vec), 32'h100);
        rst = 1'b1;
        set_in(1, 9'h100, 2, 0, 9'h000);
        chk("mid_rst_busy", 32'(busy_vec), 0);
        chk("mid_rst_ready", 32'(issue_ready), 1);
        chk("mid_rst_start", 32'(unit_start), 0);
        set_in(0, 9'h000, 0, 0, 9'h000);
        rst = 1'b0;
        set_in(1, 9'h100, 6, 0, 9'h000);
        chk("post_rst_issue", 32'(unit_start), 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
